sprite_anim_renderer: RTL and testbench
=======================================

SPRITE_ANIM_RENDERER -- requirements
Module: sprite_anim_renderer

Interface
REQ-001 Parameters (name, default, meaning):
- SPRITE_W, 64: sprite width in pixels.
- SPRITE_H, 96: sprite height in pixels.
- NUM_FRAMES, 4: animation frames, stored back-to-back in ROM.
- FRAME_TICKS, 6: frame_tick pulses per animation frame (>=1).
- INDEX_BITS, 4: palette index width.
- TRANSPARENT_INDEX, 0: palette index treated as see-through.
- ADDR_W, 15: ROM address width; SPRITE_W*SPRITE_H*NUM_FRAMES <= 2^ADDR_W.
REQ-002 Ports (name, direction, width, meaning):
- vga_clk, in, 1: sole clock; all logic on posedge.
- reset, in, 1: synchronous, active-high.
- drawX, in, 10: current pixel column.
- drawY, in, 10: current pixel row.
- blank, in, 1: 1 = active video.
- sprite_x, in, 10: sprite left edge on screen.
- sprite_y, in, 10: sprite top edge on screen.
- flip, in, 1: 1 = mirror horizontally.
- start, in, 1: begin/restart animation.
- stop, in, 1: abort to idle.
- loop, in, 1: 1 = wrap after the last frame.
- frame_tick, in, 1: one-cycle pulse per video frame (vsync).
- rom_address, out, ADDR_W: external sprite ROM address.
- rom_q, in, INDEX_BITS: ROM data, valid exactly 1 cycle after rom_address.
- pixel_index, out, INDEX_BITS: palette index for current pixel.
- pixel_valid, out, 1: 1 = draw pixel_index; 0 = show background.
- frame_idx, out, log2(NUM_FRAMES) (min 1): current animation frame.
- busy, out, 1: high in PLAY.
- done, out, 1: one-cycle pulse when a non-looping animation finishes.

Function
REQ-003 Animation FSM states: IDLE, PLAY, HOLD.
REQ-004 IDLE: frame_idx=0, busy=0; start -> PLAY with frame_idx=0, tick_cnt=0.
REQ-005 PLAY: each frame_tick increments tick_cnt; at tick_cnt==FRAME_TICKS-1, tick_cnt clears and frame advances.
REQ-006 Advance from frame NUM_FRAMES-1: loop=1 -> frame 0, stay PLAY; loop=0 -> HOLD, frame stays NUM_FRAMES-1, done=1 that cycle.
REQ-007 HOLD: busy=0, frame_idx held; start -> PLAY from frame 0.
REQ-008 stop in any state -> IDLE next cycle; stop and start together: stop wins.
REQ-009 start in PLAY restarts at frame 0, tick_cnt=0; start with frame_tick in the same cycle: the tick is ignored.
REQ-010 frame_idx changes only on the cycle after frame_tick, start, stop or reset.
REQ-011 Pipeline stage 1 (cycle N+1): register dx=drawX-sprite_x, dy=drawY-sprite_y (unsigned 10-bit) and inside=(drawX>=sprite_x)&&(dx<SPRITE_W)&&(drawY>=sprite_y)&&(dy<SPRITE_H).
REQ-012 Column col = flip ? SPRITE_W-1-dx : dx.
REQ-013 rom_address = frame_idx*SPRITE_W*SPRITE_H + dy*SPRITE_W + col, registered at N+1, truncated to ADDR_W; when inside=0, rom_address=0.
REQ-014 Stage 2 delays inside and blank 1 cycle to align with rom_q (N+2).
REQ-015 Stage 3 (N+3): pixel_index<=rom_q; pixel_valid<=inside&blank&(rom_q!=TRANSPARENT_INDEX); when pixel_valid=0, pixel_index=0.
REQ-016 Total latency drawX/drawY/blank -> pixel_index/pixel_valid: exactly 3 cycles; throughput 1 pixel/cycle, no stalls.
REQ-017 Sprite overlapping the right/bottom screen edge: pixels outside the sprite box never valid; no wrap of dx/dy into the box.

Reset
REQ-018 On reset: FSM=IDLE, frame_idx=0, tick_cnt=0, busy=0, done=0, rom_address=0, pixel_index=0, pixel_valid=0, all pipeline sideband=0.
REQ-019 Reset mid-animation or mid-line takes effect next edge and overrides start/stop/frame_tick.

Verification
REQ-020 Defaults, sprite_x=100, sprite_y=50, flip=0, frame 0, drawX=100, drawY=50, blank=1 -> rom_address=0 at N+1; with rom_q=5, pixel_index=5, pixel_valid=1 at N+3.
REQ-021 flip=1, drawX=100, drawY=51 -> rom_address=127 (64+63); drawX=99 -> pixel_valid=0 at N+3.
REQ-022 start, loop=0, 24 frame_ticks -> frame_idx 0,1,2,3 at every 6th tick; done pulses once on the 24th tick; HOLD with frame_idx=3, busy=0.
REQ-023 loop=1, 24 frame_ticks -> frame_idx returns to 0, busy stays 1, no done; frame 2 pixel (0,0) -> rom_address=12288.
REQ-024 rom_q=TRANSPARENT_INDEX inside box, or blank=0 -> pixel_valid=0, pixel_index=0.
REQ-025 start+stop same cycle in PLAY -> IDLE, frame_idx=0; reset during PLAY frame 2 -> all outputs zero next cycle.

Source files
------------

// File: rtl/sprite_anim_renderer.sv
// Animated sprite renderer: frame-sequencing FSM plus a 3-stage pixel pipeline
// that fetches palette indices from an external synchronous sprite ROM.
module sprite_anim_renderer #(
  parameter int SPRITE_W          = 64,
  parameter int SPRITE_H          = 96,
  parameter int NUM_FRAMES        = 4,
  parameter int FRAME_TICKS       = 6,
  parameter int INDEX_BITS        = 4,
  parameter int TRANSPARENT_INDEX = 0,
  parameter int ADDR_W            = 15,
  localparam int FRAME_W          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic [9:0]            drawX,
  input  logic [9:0]            drawY,
  input  logic                  blank,
  input  logic [9:0]            sprite_x,
  input  logic [9:0]            sprite_y,
  input  logic                  flip,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic                  frame_tick,
  output logic [ADDR_W-1:0]     rom_address,
  input  logic [INDEX_BITS-1:0] rom_q,
  output logic [INDEX_BITS-1:0] pixel_index,
  output logic                  pixel_valid,
  output logic [FRAME_W-1:0]    frame_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [TICK_W-1:0]     LAST_TICK  = TICK_W'(FRAME_TICKS - 1);
  localparam logic [FRAME_W-1:0]    LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [31:0]           W32        = 32'(SPRITE_W);
  localparam logic [31:0]           H32        = 32'(SPRITE_H);
  localparam logic [31:0]           FRAME_SIZE = 32'(SPRITE_W * SPRITE_H);
  localparam logic [INDEX_BITS-1:0] TRANSP     = INDEX_BITS'(TRANSPARENT_INDEX);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;

  state_t              state, state_next;
  logic [FRAME_W-1:0]  frame_next;
  logic [TICK_W-1:0]   tick_cnt, tick_next;
  logic                done_next;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state     <= IDLE;
      frame_idx <= '0;
      tick_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      frame_idx <= frame_next;
      tick_cnt  <= tick_next;
      done      <= done_next;
    end
  end

  // stop beats start, and start swallows a coincident frame_tick
  always_comb begin
    state_next = state;
    frame_next = frame_idx;
    tick_next  = tick_cnt;
    done_next  = 1'b0;
    if (stop) begin
      state_next = IDLE;
      frame_next = '0;
      tick_next  = '0;
    end else if (start) begin
      state_next = PLAY;
      frame_next = '0;
      tick_next  = '0;
    end else if (state == PLAY && frame_tick) begin
      if (tick_cnt == LAST_TICK) begin
        tick_next = '0;
        if (frame_idx == LAST_FRAME) begin
          if (loop) begin
            frame_next = '0;
          end else begin
            state_next = HOLD;
            done_next  = 1'b1;
          end
        end else begin
          frame_next = frame_idx + FRAME_W'(1);
        end
      end else begin
        tick_next = tick_cnt + TICK_W'(1);
      end
    end
  end

  always_comb begin
    busy = (state == PLAY);
  end

  logic [9:0]  dx, dy, col;
  logic        in_box;
  logic [31:0] addr_full;

  // drawX < sprite_x is checked explicitly so an underflowed dx never lands in the box
  always_comb begin
    dx        = drawX - sprite_x;
    dy        = drawY - sprite_y;
    in_box    = (drawX >= sprite_x) && ({22'd0, dx} < W32) &&
                (drawY >= sprite_y) && ({22'd0, dy} < H32);
    col       = flip ? (10'(SPRITE_W - 1) - dx) : dx;
    addr_full = 32'(frame_idx) * FRAME_SIZE + 32'(dy) * W32 + 32'(col);
  end

  logic inside_s1, blank_s1, inside_s2, blank_s2;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      inside_s1   <= 1'b0;
      blank_s1    <= 1'b0;
      inside_s2   <= 1'b0;
      blank_s2    <= 1'b0;
      pixel_index <= '0;
      pixel_valid <= 1'b0;
    end else begin
      rom_address <= in_box ? addr_full[ADDR_W-1:0] : '0;
      inside_s1   <= in_box;
      blank_s1    <= blank;
      inside_s2   <= inside_s1;
      blank_s2    <= blank_s1;
      if (inside_s2 && blank_s2 && (rom_q != TRANSP)) begin
        pixel_index <= rom_q;
        pixel_valid <= 1'b1;
      end else begin
        pixel_index <= '0;
        pixel_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed bench for sprite_anim_renderer: pixel pipeline addressing/latency
// and the animation FSM, against hand-computed values.
module tb_sprite_anim_renderer;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic [9:0]  drawX, drawY, sprite_x, sprite_y;
  logic        blank, flip, start, stop, loop, frame_tick;
  logic [14:0] rom_address;
  logic [3:0]  rom_q;
  logic [3:0]  pixel_index;
  logic        pixel_valid;
  logic [1:0]  frame_idx;
  logic        busy, done;

  int num_checks = 0;
  int num_errors = 0;

  sprite_anim_renderer dut (
    .vga_clk(vga_clk), .reset(reset), .drawX(drawX), .drawY(drawY),
    .blank(blank), .sprite_x(sprite_x), .sprite_y(sprite_y), .flip(flip),
    .start(start), .stop(stop), .loop(loop), .frame_tick(frame_tick),
    .rom_address(rom_address), .rom_q(rom_q), .pixel_index(pixel_index),
    .pixel_valid(pixel_valid), .frame_idx(frame_idx), .busy(busy), .done(done)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous ROM model: contents are (address low nibble + 5) mod 16
  always @(posedge vga_clk) rom_q <= rom_address[3:0] + 4'd5;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge vga_clk);
    #1;
  endtask

  // One pixel followed by background; checks address at N+1 and pixel at N+3
  task automatic drivePixel(input string tag, input int x, input int y, input logic fl,
                            input logic bl, input int exp_addr, input logic exp_valid,
                            input int exp_idx);
    drawX = 10'(x); drawY = 10'(y); flip = fl; blank = bl;
    applyStimulus();
    checkOutput({tag, ".addr"}, 32'(rom_address), 32'(exp_addr));
    drawX = 10'd0; drawY = 10'd0; flip = 1'b0; blank = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput({tag, ".valid"}, 32'(pixel_valid), 32'(exp_valid));
    checkOutput({tag, ".index"}, 32'(pixel_index), 32'(exp_idx));
  endtask

  task automatic pulseTick();
    frame_tick = 1'b1;
    applyStimulus();
    frame_tick = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; drawX = '0; drawY = '0; blank = 1'b1;
    sprite_x = 10'd100; sprite_y = 10'd50; flip = 1'b0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; frame_tick = 1'b0;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    checkOutput("rst.frame", 32'(frame_idx), 0);
    checkOutput("rst.busy", 32'(busy), 0);
    checkOutput("rst.done", 32'(done), 0);
    checkOutput("rst.addr", 32'(rom_address), 0);
    checkOutput("rst.valid", 32'(pixel_valid), 0);
    applyStimulus();
    applyStimulus();
    applyStimulus();

    drivePixel("origin", 100, 50, 1'b0, 1'b1, 0, 1'b1, 5);
    drivePixel("flip_row1", 100, 51, 1'b1, 1'b1, 127, 1'b1, 4);
    drivePixel("flip_left_out", 99, 51, 1'b1, 1'b1, 0, 1'b0, 0);
    drivePixel("corner", 163, 145, 1'b0, 1'b1, 6143, 1'b1, 4);
    drivePixel("right_out", 164, 50, 1'b0, 1'b1, 0, 1'b0, 0);
    drivePixel("bottom_out", 100, 146, 1'b0, 1'b1, 0, 1'b0, 0);
    drivePixel("transparent", 111, 50, 1'b0, 1'b1, 11, 1'b0, 0);
    drivePixel("blanked", 100, 50, 1'b0, 1'b0, 0, 1'b0, 0);
    sprite_x = 10'd1000;
    drivePixel("edge_nowrap", 5, 50, 1'b0, 1'b1, 0, 1'b0, 0);
    drivePixel("edge_inside", 1010, 50, 1'b0, 1'b1, 10, 1'b1, 15);
    sprite_x = 10'd100;

    // Non-looping animation
    loop = 1'b0;
    pulseStart();
    checkOutput("play.busy", 32'(busy), 1);
    checkOutput("play.frame", 32'(frame_idx), 0);
    for (int k = 1; k <= 24; k++) begin
      pulseTick();
      checkOutput($sformatf("once.frame%0d", k), 32'(frame_idx), (k == 24) ? 3 : k / 6);
      checkOutput($sformatf("once.done%0d", k), 32'(done), (k == 24) ? 1 : 0);
      checkOutput($sformatf("once.busy%0d", k), 32'(busy), (k == 24) ? 0 : 1);
      applyStimulus();
    end
    checkOutput("hold.done_pulse", 32'(done), 0);
    checkOutput("hold.frame", 32'(frame_idx), 3);
    stop = 1'b1;
    applyStimulus();
    stop = 1'b0;
    checkOutput("stop_hold.frame", 32'(frame_idx), 0);
    checkOutput("stop_hold.busy", 32'(busy), 0);

    // Looping animation
    loop = 1'b1;
    pulseStart();
    for (int k = 1; k <= 24; k++) begin
      pulseTick();
      checkOutput($sformatf("loop.done%0d", k), 32'(done), 0);
      applyStimulus();
    end
    checkOutput("loop.frame", 32'(frame_idx), 0);
    checkOutput("loop.busy", 32'(busy), 1);
    for (int k = 1; k <= 12; k++) begin
      pulseTick();
      applyStimulus();
    end
    checkOutput("loop.frame2", 32'(frame_idx), 2);
    drivePixel("frame2_origin", 100, 50, 1'b0, 1'b1, 12288, 1'b1, 5);

    // start with frame_tick: tick ignored, count restarts
    pulseStart();
    for (int k = 1; k <= 5; k++) begin
      pulseTick();
      applyStimulus();
    end
    start = 1'b1; frame_tick = 1'b1;
    applyStimulus();
    start = 1'b0; frame_tick = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      pulseTick();
      applyStimulus();
    end
    checkOutput("restart.frame0", 32'(frame_idx), 0);
    pulseTick();
    checkOutput("restart.frame1", 32'(frame_idx), 1);

    // start and stop together in PLAY
    start = 1'b1; stop = 1'b1;
    applyStimulus();
    start = 1'b0; stop = 1'b0;
    checkOutput("startstop.busy", 32'(busy), 0);
    checkOutput("startstop.frame", 32'(frame_idx), 0);

    // Reset during PLAY frame 2 with a valid pixel in flight
    pulseStart();
    for (int k = 1; k <= 12; k++) begin
      pulseTick();
      applyStimulus();
    end
    checkOutput("prereset.frame", 32'(frame_idx), 2);
    drawX = 10'd100; drawY = 10'd50; blank = 1'b1;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("prereset.valid", 32'(pixel_valid), 1);
    reset = 1'b1; start = 1'b1; frame_tick = 1'b1;
    applyStimulus();
    checkOutput("midreset.frame", 32'(frame_idx), 0);
    checkOutput("midreset.busy", 32'(busy), 0);
    checkOutput("midreset.done", 32'(done), 0);
    checkOutput("midreset.addr", 32'(rom_address), 0);
    checkOutput("midreset.valid", 32'(pixel_valid), 0);
    checkOutput("midreset.index", 32'(pixel_index), 0);
    reset = 1'b0; start = 1'b0; frame_tick = 1'b0;
    applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
